// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter. Pipeline writeback always owns the port; results from the
// long-latency unit wait in a 2-entry ordered buffer that drains on idle writeback cycles.
module wb_port_arbiter #(
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wb_RegWrite,
    input  logic [4:0]  wb_DestReg,
    input  logic [31:0] wb_data,
    input  logic        lu_valid,
    input  logic [4:0]  lu_DestReg,
    input  logic [31:0] lu_data,
    output logic        lu_ready,
    input  logic [4:0]  rs_in,
    input  logic [4:0]  rt_in,
    output logic        pend_rs,
    output logic        pend_rt,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        stall_req
);
    localparam int unsigned REG_W  = 5;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 4;

    logic [1:0]        count, countNext;
    logic [REG_W-1:0]  dest0, dest1, dest0Next, dest1Next;
    logic [DATA_W-1:0] data0, data1, data0Next, data1Next;
    logic [CNT_W-1:0]  starve, starveNext;
    logic              stallNext;
    logic              readyEn;

    logic              pipeActive, drain, accept, store, headLeave;
    logic              live0, live1;
    logic [REG_W-1:0]  tDest0, tDest1;
    logic [DATA_W-1:0] tData0, tData1;

    // Gating with rst_n keeps the port quiet while reset is held.
    assign pipeActive = rst_n && wb_RegWrite && (wb_DestReg != '0);
    assign lu_ready   = readyEn && (count != 2'd2);
    assign accept     = lu_valid && lu_ready;
    assign store      = accept && (lu_DestReg != '0) && !(pipeActive && (lu_DestReg == wb_DestReg));
    assign drain      = !pipeActive && (count != 2'd0);
    assign headLeave  = (count != 2'd0) && (drain || (pipeActive && (dest0 == wb_DestReg)));

    assign pend_rs = (rs_in != '0) && (((count != 2'd0) && (dest0 == rs_in)) ||
                                       ((count == 2'd2) && (dest1 == rs_in)));
    assign pend_rt = (rt_in != '0) && (((count != 2'd0) && (dest0 == rt_in)) ||
                                       ((count == 2'd2) && (dest1 == rt_in)));

    // Write-port select
    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = '0;
        rf_wdata = '0;
        if (pipeActive) begin
            rf_we    = 1'b1;
            rf_waddr = wb_DestReg;
            rf_wdata = wb_data;
        end else if (count != 2'd0) begin
            rf_we    = 1'b1;
            rf_waddr = dest0;
            rf_wdata = data0;
        end
    end

    // Buffer update: drain head, kill WAW matches, compact, then append at the tail
    always_comb begin
        dest0Next = dest0;
        dest1Next = dest1;
        data0Next = data0;
        data1Next = data1;
        countNext = 2'd0;
        tDest0    = dest0;
        tData0    = data0;
        tDest1    = dest1;
        tData1    = data1;
        live0     = (count != 2'd0);
        live1     = (count == 2'd2);
        if (drain) begin
            tDest0 = dest1;
            tData0 = data1;
            live0  = (count == 2'd2);
            live1  = 1'b0;
        end
        if (pipeActive && (tDest0 == wb_DestReg)) live0 = 1'b0;
        if (pipeActive && (tDest1 == wb_DestReg)) live1 = 1'b0;
        if (live0) begin
            dest0Next = tDest0;
            data0Next = tData0;
            countNext = 2'd1;
            if (live1) begin
                dest1Next = tDest1;
                data1Next = tData1;
                countNext = 2'd2;
            end
        end else if (live1) begin
            dest0Next = tDest1;
            data0Next = tData1;
            countNext = 2'd1;
        end
        if (store) begin
            if (countNext == 2'd0) begin
                dest0Next = lu_DestReg;
                data0Next = lu_data;
            end else begin
                dest1Next = lu_DestReg;
                data1Next = lu_data;
            end
            countNext = countNext + 2'd1;
        end
    end

    // Head starvation counter and stall request
    always_comb begin
        starveNext = starve;
        stallNext  = stall_req;
        if ((count == 2'd0) || headLeave) begin
            starveNext = '0;
            stallNext  = 1'b0;
        end else begin
            if (starve < CNT_W'(STARVE_LIMIT)) starveNext = starve + CNT_W'(1);
            if (starveNext == CNT_W'(STARVE_LIMIT)) stallNext = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count     <= 2'd0;
            dest0     <= '0;
            dest1     <= '0;
            data0     <= '0;
            data1     <= '0;
            starve    <= '0;
            stall_req <= 1'b0;
            readyEn   <= 1'b0;
        end else begin
            count     <= countNext;
            dest0     <= dest0Next;
            dest1     <= dest1Next;
            data0     <= data0Next;
            data1     <= data1Next;
            starve    <= starveNext;
            stall_req <= stallNext;
            readyEn   <= 1'b1;
        end
    end
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: per-cycle vectors with hand-derived expected port outputs,
// queued when driven and compared at the following falling edge.
module tb_wb_port_arbiter;
    localparam int unsigned LIM = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wb_RegWrite = 1'b0;
    logic [4:0]  wb_DestReg = '0;
    logic [31:0] wb_data = '0;
    logic        lu_valid = 1'b0;
    logic [4:0]  lu_DestReg = '0;
    logic [31:0] lu_data = '0;
    logic        lu_ready;
    logic [4:0]  rs_in = '0;
    logic [4:0]  rt_in = '0;
    logic        pend_rs, pend_rt, rf_we, stall_req;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    int nCompared = 0;
    int nMismatch = 0;

    typedef struct {
        logic        we;
        logic [4:0]  wd;
        logic [31:0] wdat;
        logic        lv;
        logic [4:0]  ld;
        logic [31:0] ldat;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic        eWe;
        logic [4:0]  eAddr;
        logic [31:0] eData;
        logic        eRdy;
        logic        ePrs;
        logic        ePrt;
        logic        eStall;
    } vec_t;

    vec_t tbl[$];
    vec_t expq[$];

    wb_port_arbiter #(.STARVE_LIMIT(LIM)) dut (
        .clk(clk), .rst_n(rst_n),
        .wb_RegWrite(wb_RegWrite), .wb_DestReg(wb_DestReg), .wb_data(wb_data),
        .lu_valid(lu_valid), .lu_DestReg(lu_DestReg), .lu_data(lu_data), .lu_ready(lu_ready),
        .rs_in(rs_in), .rt_in(rt_in), .pend_rs(pend_rs), .pend_rt(pend_rt),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .stall_req(stall_req)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mkv(input logic we, input logic [4:0] wd, input logic [31:0] wdat,
                                 input logic lv, input logic [4:0] ld, input logic [31:0] ldat,
                                 input logic [4:0] rs, input logic [4:0] rt,
                                 input logic eWe, input logic [4:0] eAddr, input logic [31:0] eData,
                                 input logic eRdy, input logic ePrs, input logic ePrt,
                                 input logic eStall);
        vec_t v;
        v.we = we; v.wd = wd; v.wdat = wdat; v.lv = lv; v.ld = ld; v.ldat = ldat;
        v.rs = rs; v.rt = rt; v.eWe = eWe; v.eAddr = eAddr; v.eData = eData;
        v.eRdy = eRdy; v.ePrs = ePrs; v.ePrt = ePrt; v.eStall = eStall;
        return v;
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatch++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        wb_RegWrite = v.we; wb_DestReg = v.wd; wb_data = v.wdat;
        lu_valid = v.lv; lu_DestReg = v.ld; lu_data = v.ldat;
        rs_in = v.rs; rt_in = v.rt;
    endtask

    task automatic checkHead(input string tag);
        vec_t e;
        nCompared++;
        if (expq.size() == 0) begin
            nMismatch++;
            $display("FAIL %s: scoreboard empty, got nothing expected an entry", tag);
            return;
        end
        nCompared--;
        e = expq.pop_front();
        cmp({tag, ".rf_we"},     32'(rf_we),     32'(e.eWe));
        cmp({tag, ".rf_waddr"},  32'(rf_waddr),  32'(e.eAddr));
        cmp({tag, ".rf_wdata"},  rf_wdata,       e.eData);
        cmp({tag, ".lu_ready"},  32'(lu_ready),  32'(e.eRdy));
        cmp({tag, ".pend_rs"},   32'(pend_rs),   32'(e.ePrs));
        cmp({tag, ".pend_rt"},   32'(pend_rt),   32'(e.ePrt));
        cmp({tag, ".stall_req"}, 32'(stall_req), 32'(e.eStall));
    endtask

    // Drive at posedge+1, compare at negedge, return at next posedge+1
    task automatic step(input string tag, input vec_t v);
        expq.push_back(v);
        drive(v);
        @(negedge clk);
        checkHead(tag);
        @(posedge clk);
        #1;
    endtask

    // Busy writeback, buffer r3 and r4, wait until the head has starved past the limit
    task automatic fillStarve(input string tag);
        step({tag, ".s1"}, mkv(1, 5'd20, 32'd20, 1, 5'd3, 32'h333, 5'd3, 5'd4,
                              1, 5'd20, 32'd20, 1, 0, 0, 0));
        step({tag, ".s2"}, mkv(1, 5'd21, 32'd21, 1, 5'd4, 32'h444, 5'd3, 5'd4,
                              1, 5'd21, 32'd21, 1, 1, 0, 0));
        for (int j = 1; j < int'(LIM); j++)
            step({tag, ".wait"}, mkv(1, 5'(21 + j), 32'(21 + j), 1, 5'd8, 32'h888, 5'd3, 5'd4,
                                    1, 5'(21 + j), 32'(21 + j), 0, 1, 1, 0));
        for (int j = 0; j < 2; j++)
            step({tag, ".stall"}, mkv(1, 5'(29 + j), 32'(29 + j), 1, 5'd8, 32'h888, 5'd3, 5'd4,
                                     1, 5'(29 + j), 32'(29 + j), 0, 1, 1, 1));
    endtask

    initial begin
        // idle/accept/drain, WAW kill, same-cycle discard, r0 accept, full-buffer drain
        tbl.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 0,            0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mkv(0, 0, 0, 1, 5'd5, 32'h1234, 5'd5, 0, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mkv(0, 0, 0, 0, 0, 0, 5'd5, 0,          1, 5'd5, 32'h1234, 1, 1, 0, 0));
        tbl.push_back(mkv(0, 0, 0, 0, 0, 0, 5'd5, 0,          0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mkv(0, 0, 0, 1, 5'd7, 32'h77, 0, 0,     0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mkv(1, 5'd7, 32'hAA, 0, 0, 0, 5'd7, 5'd7, 1, 5'd7, 32'hAA, 1, 1, 1, 0));
        tbl.push_back(mkv(0, 0, 0, 0, 0, 0, 5'd7, 5'd7,      0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mkv(1, 5'd9, 32'h99, 1, 5'd9, 32'h55, 5'd9, 0, 1, 5'd9, 32'h99, 1, 0, 0, 0));
        tbl.push_back(mkv(0, 0, 0, 1, 5'd0, 32'h66, 0, 0,     0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mkv(0, 0, 0, 0, 0, 0, 5'd9, 0,          0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mkv(1, 5'd1, 32'd1, 1, 5'd10, 32'hA0, 0, 0, 1, 5'd1, 32'd1, 1, 0, 0, 0));
        tbl.push_back(mkv(1, 5'd2, 32'd2, 1, 5'd11, 32'hB0, 5'd10, 5'd11, 1, 5'd2, 32'd2, 1, 1, 0, 0));
        tbl.push_back(mkv(0, 0, 0, 1, 5'd12, 32'hC0, 5'd11, 5'd12, 1, 5'd10, 32'hA0, 0, 1, 0, 0));
        tbl.push_back(mkv(0, 0, 0, 1, 5'd12, 32'hC0, 5'd12, 0, 1, 5'd11, 32'hB0, 1, 0, 0, 0));
        tbl.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 0,            1, 5'd12, 32'hC0, 1, 0, 0, 0));
        tbl.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 0,            0, 0, 0, 1, 0, 0, 0));

        // Reset state, with a live-looking writeback and lu request held during reset
        drive(mkv(1, 5'd6, 32'h6, 1, 5'd5, 32'h5, 5'd5, 5'd6, 0, 0, 0, 0, 0, 0, 0));
        #2;
        expq.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        checkHead("reset");
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++)
            step($sformatf("vec%0d", i), tbl[i]);

        // Starvation: bubble drains r3 and drops stall, then r4 drains
        fillStarve("starve");
        step("bubble", mkv(0, 0, 0, 0, 0, 0, 5'd3, 5'd4, 1, 5'd3, 32'h333, 0, 1, 1, 1));
        step("drainR4", mkv(0, 0, 0, 0, 0, 0, 5'd3, 5'd4, 1, 5'd4, 32'h444, 1, 0, 1, 0));
        step("drained", mkv(0, 0, 0, 0, 0, 0, 5'd3, 5'd4, 0, 0, 0, 1, 0, 0, 0));

        // Kill of the only entry while saturated clears stall
        step("kill.acc", mkv(1, 5'd20, 32'd20, 1, 5'd6, 32'h66, 5'd6, 0, 1, 5'd20, 32'd20, 1, 0, 0, 0));
        for (int j = 0; j < int'(LIM); j++)
            step("kill.wait", mkv(1, 5'(21 + j), 32'(j), 0, 0, 0, 5'd6, 0,
                                  1, 5'(21 + j), 32'(j), 1, 1, 0, 0));
        step("kill.sat", mkv(1, 5'd30, 32'd30, 0, 0, 0, 5'd6, 0, 1, 5'd30, 32'd30, 1, 1, 0, 1));
        step("kill.hit", mkv(1, 5'd6, 32'hEE, 0, 0, 0, 5'd6, 0, 1, 5'd6, 32'hEE, 1, 1, 0, 1));
        step("kill.after", mkv(0, 0, 0, 0, 0, 0, 5'd6, 0, 0, 0, 0, 1, 0, 0, 0));

        // Asynchronous reset with a full, starved buffer
        fillStarve("rst");
        drive(mkv(0, 0, 0, 1, 5'd5, 32'h5, 5'd3, 5'd4, 0, 0, 0, 0, 0, 0, 0));
        #2 rst_n = 1'b0;
        #1;
        expq.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        checkHead("midReset");
        @(posedge clk);
        #1 rst_n = 1'b1;
        step("postRst0", mkv(0, 0, 0, 0, 0, 0, 5'd3, 5'd4, 0, 0, 0, 0, 0, 0, 0));
        step("postRst1", mkv(0, 0, 0, 0, 0, 0, 5'd3, 5'd4, 0, 0, 0, 1, 0, 0, 0));
        step("postRst2", mkv(0, 0, 0, 0, 0, 0, 5'd3, 5'd4, 0, 0, 0, 1, 0, 0, 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end
endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Shares the single register-file write port between the MEM/WB pipeline writeback and a long-latency execution unit (multiply/divide) that completes out of band. Pipeline writeback always wins the port. Long-latency results wait in a 2-entry ordered buffer and drain on idle writeback cycles. The block raises a stall request when a buffered result starves, kills buffered results overwritten by younger pipeline writes (WAW), and reports pending destinations to the hazard unit.

## Interface
- STARVE_LIMIT, 8: cycles a buffered head may wait before stall_req asserts (1..15)
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous, active-low reset
- wb_RegWrite  input  1  writeback-stage write enable from MEM/WB register
- wb_DestReg  input  5  writeback-stage destination register
- wb_data  input  32  writeback data, already muxed by MemToReg
- lu_valid  input  1  long-latency unit presents a result
- lu_DestReg  input  5  destination of that result
- lu_data  input  32  result value
- lu_ready  output  1  buffer can accept; transfer when lu_valid & lu_ready
- rs_in, rt_in  input  5 each  decode-stage source registers for pending check
- pend_rs, pend_rt  output  1 each  source matches a buffered destination
- rf_we  output  1  register-file write enable
- rf_waddr  output  5  register-file write address
- rf_wdata  output  32  register-file write data
- stall_req  output  1  request to the hazard unit to freeze fetch/decode

## Operation
- Buffer: slots 0 (oldest) and 1; each holds {dest, data}; count 0..2. No invalid holes: removal compacts slot 1 into slot 0 on the same edge.
- A pipeline write is active when wb_RegWrite=1 and wb_DestReg≠0.
- Port select (combinational):
  - pipeline write active: rf_we=1, rf_waddr=wb_DestReg, rf_wdata=wb_data;
  - else count>0: rf_we=1 with slot 0 contents (drain);
  - else rf_we=0, rf_waddr=0, rf_wdata=0.
- An lu result never writes the port in the cycle it is accepted; minimum accept-to-write latency is 1 cycle.
- lu_ready = (count<2). It depends on registered state only and ignores a same-cycle drain.
- Accept with lu_DestReg=0: handshake completes, nothing stored.
- Lu results are older than any concurrent writeback instruction. Therefore:
  - an active pipeline write whose dest matches a buffered entry removes that entry at the edge;
  - an accepted lu result whose dest equals the active pipeline dest in the same cycle is discarded.
- Simultaneous drain, kill and accept resolve in this order: drain slot 0, kill matches among remaining entries, compact, append the incoming entry at the tail.
- pend_rs = rs_in≠0 and it matches any buffered dest; pend_rt likewise. Both are combinational from buffer state.
- Starvation counter (4 bits):
  - increments each cycle count>0 and the head is not drained or killed;
  - clears when the head leaves the buffer or count=0;
  - saturates at STARVE_LIMIT.
- stall_req is registered. It sets on the edge where the counter reaches STARVE_LIMIT and clears on the edge where the head leaves the buffer.

## Timing
- Reset (rst_n low, asynchronous):
  - count=0, counter=0, stall_req=0, lu_ready=0;
  - rf_we=0, rf_waddr=0, rf_wdata=0, pend_rs=pend_rt=0.
- lu_ready rises on the first clock edge after rst_n deasserts.
- Reset mid-operation discards buffered results silently.
- Port outputs are combinational; the register file samples them on the same rising edge.
- Full buffer (count=2): lu_ready=0 even while draining. The next accept happens one cycle after the drain.
- A kill of the only entry while the counter is saturated drops stall_req on the next edge.
- stall_req stays asserted until the head drains. Bubbles reach writeback only after the pipeline depth, so stall_req may remain high several cycles.

## Test plan
- Idle pipeline: lu result r5=0x1234 accepted at cycle 0 -> rf_we=1, rf_waddr=5, rf_wdata=0x1234 at cycle 1; lu_ready high throughout.
- Writeback busy every cycle; two lu results (r3, r4) accepted -> lu_ready=0 after the second; STARVE_LIMIT=8 -> stall_req=1 on the edge after 8 waiting cycles. Inject one bubble -> r3 written, stall_req=0 next edge; r4 written on the following idle cycle.
- Buffered r7 pending; pipeline writes r7=0xAA -> r7 entry removed, count decrements, r7 never rewritten with the stale value; pend_rs for rs_in=7 falls.
- Same cycle: pipeline writes r9, lu accepted for r9 -> lu result discarded, count unchanged; lu result for r0 -> accepted, nothing stored.
- Full buffer, head drains while lu_valid=1 -> no accept that cycle; accept on the next cycle; ordering preserved (older entry written first).
- Assert rst_n low with count=2 and stall_req=1 -> all outputs zero immediately without a clock edge; after release, no buffered writes occur.
